tdc_fine_encoder: RTL and testbench

TDC_FINE_ENCODER -- requirements
Module: tdc_fine_encoder

---
 rtl/tdc_pkg.sv | 21 ++
 rtl/tdc_therm2bin.sv | 30 +++
 rtl/tdc_fine_encoder.sv | 94 +++++++++
 tb/tb_tdc_fine_encoder.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared state type, default sizes and clog2 helper for the TDC fine encoder
package tdc_pkg;

   typedef enum logic {
      ARMED      = 1'b0,
      WAIT_CLEAR = 1'b1
   } tdc_state_t;

   localparam int DEF_NTAPS    = 16;
   localparam int DEF_COARSE_W = 16;
   localparam int DEF_OVF_W    = 8;

   // Ceiling log2, usable in constant expressions
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/tdc_therm2bin.sv
// rtl/tdc_therm2bin.sv - thermometer to binary fine code; TDC_BUBBLE_FILTER_EN selects popcount
module tdc_therm2bin
   import tdc_pkg::*;
#(
   parameter int NTAPS = DEF_NTAPS,
   localparam int FINE_W = clog2(NTAPS + 1)
) (
   input  logic [NTAPS-1:0]  taps,
   output logic [FINE_W-1:0] fine
);

`ifdef TDC_BUBBLE_FILTER_EN
   // Popcount: a stray 0 inside the ones run costs one tap, not the whole code
   always_comb begin
      fine = '0;
      for (int i = 0; i < NTAPS; i++) begin
         fine = fine + FINE_W'(taps[i]);
      end
   end
`else
   // Leading-ones count: index of the lowest 0 tap, NTAPS when the line is full
   always_comb begin
      fine = FINE_W'(NTAPS);
      for (int i = NTAPS - 1; i >= 0; i--) begin
         if (!taps[i]) fine = FINE_W'(i);
      end
   end
`endif

endmodule

// File: rtl/tdc_fine_encoder.sv
// rtl/tdc_fine_encoder.sv - carry-chain TDC hit capture with coarse stamp; TDC_BUBBLE_FILTER_EN via tdc_therm2bin
module tdc_fine_encoder
   import tdc_pkg::*;
#(
   parameter int NTAPS    = DEF_NTAPS,
   parameter int COARSE_W = DEF_COARSE_W,
   parameter int OVF_W    = DEF_OVF_W,
   localparam int FINE_W  = clog2(NTAPS + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NTAPS-1:0]    TAPS,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [COARSE_W-1:0] out_coarse,
   output logic [FINE_W-1:0]   out_fine,
   output logic                out_sat,
   output logic [OVF_W-1:0]    ovf_count
);

   logic [COARSE_W-1:0] coarse;
   logic [NTAPS-1:0]    s1_taps, s2_taps;
   logic [COARSE_W-1:0] s1_coarse, s2_coarse;
   logic [FINE_W-1:0]   fine;
   tdc_state_t          state, state_nxt;
   logic                hit, load, drop;

   tdc_therm2bin #(.NTAPS(NTAPS)) u_therm2bin (
      .taps (s2_taps),
      .fine (fine)
   );

   // Free-running coarse counter and two-flop synchronizer; the coarse stamp
   // travels with the taps so it stays aligned to the sample it belongs to
   always_ff @(posedge clk) begin
      if (rst) begin
         coarse    <= '0;
         s1_taps   <= '0;
         s1_coarse <= '0;
         s2_taps   <= '0;
         s2_coarse <= '0;
      end else begin
         coarse    <= coarse + COARSE_W'(1);
         s1_taps   <= TAPS;
         s1_coarse <= coarse;
         s2_taps   <= s1_taps;
         s2_coarse <= s1_coarse;
      end
   end

   assign hit  = (state == ARMED) && s2_taps[0];
   assign load = hit && (!out_valid || out_ready);
   assign drop = hit && out_valid && !out_ready;

   // Edge detector: one hit per rising first tap, re-armed once it falls
   always_comb begin
      state_nxt = state;
      case (state)
         ARMED:      if (hit) state_nxt = WAIT_CLEAR;
         WAIT_CLEAR: if (!s2_taps[0]) state_nxt = ARMED;
         default:    state_nxt = ARMED;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ARMED;
      else     state <= state_nxt;
   end

   // One-deep output holding register plus saturating drop counter
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_coarse <= '0;
         out_fine   <= '0;
         out_sat    <= 1'b0;
         ovf_count  <= '0;
      end else begin
         if (load) begin
            out_valid  <= 1'b1;
            out_coarse <= s2_coarse;
            out_fine   <= fine;
            out_sat    <= &s2_taps;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (drop && (ovf_count != {OVF_W{1'b1}})) begin
            ovf_count <= ovf_count + OVF_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_tdc_fine_encoder.sv
// tb/tb_tdc_fine_encoder.sv - directed self-checking bench for tdc_fine_encoder
module tb_tdc_fine_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] taps;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_coarse;
   logic [4:0]  out_fine;
   logic        out_sat;
   logic [7:0]  ovf_count;

   int total = 0;
   int bad   = 0;

   logic [15:0] cyc;
   logic [15:0] exp_c;
   int          nvalid;
   int          guard;

   always #5 clk = ~clk;

   // Expected coarse counter value: reset to 0, +1 per edge
   always @(posedge clk) begin
      if (rst) cyc <= 16'd0;
      else     cyc <= cyc + 16'd1;
   end

   tdc_fine_encoder dut (
      .clk        (clk),
      .rst        (rst),
      .TAPS       (taps),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_coarse (out_coarse),
      .out_fine   (out_fine),
      .out_sat    (out_sat),
      .ovf_count  (ovf_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; taps = 16'h0; out_ready = 1'b0;
      step(3);
      chk("rst_valid", out_valid, 0);
      chk("rst_fine", out_fine, 0);
      chk("rst_sat", out_sat, 0);
      chk("rst_coarse", out_coarse, 0);
      chk("rst_ovf", ovf_count, 0);
      rst = 1'b0;
      step(3);

      // Thermometer 003F, latency check
      exp_c = cyc; taps = 16'h003F;
      step(1); chk("lat_e1_valid", out_valid, 0);
      step(1); chk("lat_e2_valid", out_valid, 0);
      step(1); chk("lat_e3_valid", out_valid, 1);
      chk("t3f_fine", out_fine, 6);
      chk("t3f_sat", out_sat, 0);
      chk("t3f_coarse", out_coarse, exp_c);
      taps = 16'h0; out_ready = 1'b1;
      step(1); chk("t3f_clear", out_valid, 0);
      step(4);

      // Full line: saturation
      taps = 16'hFFFF;
      step(3);
      chk("sat_valid", out_valid, 1);
      chk("sat_fine", out_fine, 16);
      chk("sat_sat", out_sat, 1);
      taps = 16'h0;
      step(5);

      // Bubble at bit 3
      taps = 16'h00F7;
      step(3);
      chk("bub_valid", out_valid, 1);
`ifdef TDC_BUBBLE_FILTER_EN
      chk("bub_fine", out_fine, 7);
`else
      chk("bub_fine", out_fine, 3);
`endif
      chk("bub_sat", out_sat, 0);
      taps = 16'h0;
      step(5);

      // Overflow: consumer stalled, second hit dropped
      out_ready = 1'b0;
      exp_c = cyc; taps = 16'h0003;
      step(3);
      chk("ovf_first_valid", out_valid, 1);
      chk("ovf_first_fine", out_fine, 2);
      taps = 16'h0;
      step(4);
      taps = 16'h001F;
      step(4);
      chk("ovf_hold_valid", out_valid, 1);
      chk("ovf_hold_fine", out_fine, 2);
      chk("ovf_hold_coarse", out_coarse, exp_c);
      chk("ovf_count1", ovf_count, 1);
      taps = 16'h0;
      step(4);
      out_ready = 1'b1;
      step(1); chk("ovf_lost", out_valid, 0);
      step(3); chk("ovf_count_keep", ovf_count, 1);

      // Long pulse: exactly one timestamp
      taps = 16'h0001; nvalid = 0;
      for (int i = 0; i < 12; i++) begin
         step(1);
         if (out_valid) nvalid++;
         if (i == 9) taps = 16'h0;
      end
      chk("long_one_ts", nvalid, 1);
      step(4);
      taps = 16'h0001;
      step(3);
      chk("rearm_valid", out_valid, 1);
      chk("rearm_fine", out_fine, 1);
      taps = 16'h0;
      step(5);

      // Coarse wrap between capture and output
      guard = 0;
      while (cyc != 16'hFFFF && guard < 70000) begin
         step(1); guard++;
      end
      chk("wrap_reach", (guard < 70000), 1);
      taps = 16'h0001; out_ready = 1'b0;
      step(3);
      chk("wrap_valid", out_valid, 1);
      chk("wrap_coarse", out_coarse, 16'hFFFF);

      // Reset while holding a timestamp
      rst = 1'b1;
      step(1);
      chk("rstmid_valid", out_valid, 0);
      chk("rstmid_ovf", ovf_count, 0);
      chk("rstmid_coarse", out_coarse, 0);
      rst = 1'b0; taps = 16'h0;
      step(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
